channel_sequencer: RTL and testbench
====================================

CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

Interface
REQ-001 Parameter NUM_CHANNEL, default 3, number of input-feature-map channels per layer (at least 1).
REQ-002 Parameter IFM_WIDTH, default 9, input-feature-map width in pixels.
REQ-003 Parameter IFM_HEIGHT, default 9, input-feature-map height in pixels.
REQ-004 Parameter KERNEL_SIZE, default 3, pipeline fill tail in beats appended to each channel.
REQ-005 Parameter CNT_W, default 16, width of the pixel counter.
REQ-006 Derived constants SHALL be CH_LEN = IFM_WIDTH*IFM_HEIGHT + KERNEL_SIZE and CH_W = max(1, clog2(NUM_CHANNEL)).
REQ-007 clk1  input  1  clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  layer start request; sampled only in IDLE.
REQ-010 ifm_valid  input  1  upstream beat valid.
REQ-011 ifm_ready  output  1  beat accept; a beat transfers when ifm_valid and ifm_ready are both high.
REQ-012 pix_cnt  output  CNT_W  beats accepted in the current channel.
REQ-013 ch_idx  output  CH_W  index of the current channel.
REQ-014 end_channel  output  1  one-cycle pulse after each channel completes.
REQ-015 end_layer  output  1  one-cycle pulse after the last channel completes.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and GAP.
REQ-018 Transitions: IDLE->RUN on start; RUN->GAP on the final beat of a non-last channel; RUN->IDLE on the final beat of the last channel; GAP->RUN unconditionally after one cycle.
REQ-019 ifm_ready SHALL be high only in RUN; it is a registered-state decode with no combinational path from ifm_valid.
REQ-020 pix_cnt SHALL increment by 1 per accepted beat.
REQ-021 The beat accepted while pix_cnt == CH_LEN-1 is the channel's final beat; pix_cnt SHALL become 0 on the next edge.
REQ-022 ch_idx SHALL increment on a final beat when ch_idx < NUM_CHANNEL-1, and SHALL clear to 0 on the final beat of the last channel.
REQ-023 end_channel SHALL be registered and high for exactly the one cycle following each final beat.
REQ-024 end_layer SHALL be high in the same cycle as the last channel's end_channel, and in no other cycle.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 A start in the cycle where end_layer is high SHALL be accepted, since the FSM is already in IDLE.
REQ-027 ifm_valid low in RUN SHALL stall the counters; no pulses are emitted during a stall.
REQ-028 If CNT_W cannot represent CH_LEN-1, elaboration SHALL fail.

Reset
REQ-029 While rst_n is low: state = IDLE; pix_cnt, ch_idx, end_channel, end_layer, busy and ifm_ready = 0.
REQ-030 Reset asserted mid-layer SHALL discard all progress and emit no pulse on release.

Configuration
REQ-031 With CHANNEL_SEQ_ABORT_EN defined, the block SHALL add input port abort (1 bit).
REQ-032 abort high on an edge SHALL force IDLE and clear pix_cnt and ch_idx, with no end_channel or end_layer on the next cycle.
REQ-033 abort SHALL take priority over a simultaneous final beat and over start.
REQ-034 Without CHANNEL_SEQ_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be as REQ-017..030.

Structure
REQ-035 Package eyeriss_ctrl_pkg SHALL hold the state enum (IDLE, RUN, GAP) and the function ch_len(w,h,k).
REQ-036 Sub-module wrap_counter (parameterised width and terminal value; inputs en and clr; outputs count and wrap) SHALL be instantiated twice: once for pixels, once for channels.

Verification
REQ-037 Defaults, start pulse, ifm_valid held high -> 84 beats per channel; end_channel at cycles 85, 170 and 255 after the first RUN cycle; end_layer with the third; 252 beats total.
REQ-038 ifm_valid toggled 50% random -> pix_cnt and ch_idx frozen on low cycles; pulses delayed only by stall count; still 252 beats accepted.
REQ-039 start asserted again at beat 40 of channel 1 -> ignored; ch_idx=1 and pix_cnt continue unchanged.
REQ-040 rst_n low at ch_idx=2, pix_cnt=50 -> all outputs 0 asynchronously; no pulses after release; a new start runs a full layer.
REQ-041 NUM_CHANNEL=1, IFM 4x4, KERNEL_SIZE=1 -> 17 beats; end_channel and end_layer together; start in that same cycle begins a new layer.
REQ-042 CHANNEL_SEQ_ABORT_EN defined, abort coincident with final beat of channel 2 -> IDLE, counters 0, no end pulses.

Source files
------------

// File: rtl/eyeriss_ctrl_pkg.sv
// Shared types and helpers for the eyeriss layer control slice.
// Channel length helper and sequencer state encoding.
package eyeriss_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  function automatic int ch_len(
    input int w,
    input int h,
    input int k
  );
    return w * h + k;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that returns to zero after TERM.
// wrap flags the enabled cycle in which count equals TERM.
module wrap_counter #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(TERM));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/channel_sequencer.sv
// Per-layer channel/pixel sequencer with a one-cycle gap between channels.
// Optional abort input is enabled by defining CHANNEL_SEQ_ABORT_EN.
module channel_sequencer
  import eyeriss_ctrl_pkg::*;
#(
  parameter int  NUM_CHANNEL = 3,
  parameter int  IFM_WIDTH   = 9,
  parameter int  IFM_HEIGHT  = 9,
  parameter int  KERNEL_SIZE = 3,
  parameter int  CNT_W       = 16,
  localparam int CH_LEN      = ch_len(IFM_WIDTH, IFM_HEIGHT, KERNEL_SIZE),
  localparam int CH_W        = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ifm_valid,
`ifdef CHANNEL_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             ifm_ready,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CH_W-1:0]  ch_idx,
  output logic             end_channel,
  output logic             end_layer,
  output logic             busy
);

  if ((CNT_W < 32) && ((CH_LEN - 1) >= (1 << CNT_W))) begin : g_cnt_w_check
    $error("CNT_W cannot hold CH_LEN-1");
  end

  seq_state_t state;
  logic       beat;
  logic       pix_wrap;
  logic       ch_wrap;
  logic       kill;

`ifdef CHANNEL_SEQ_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Ready is a pure decode of registered state.
  assign ifm_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign beat      = ifm_valid && ifm_ready;

  wrap_counter #(
    .W    (CNT_W),
    .TERM (CH_LEN - 1)
  ) u_pix (
    .clk1  (clk1),
    .rst_n (rst_n),
    .en    (beat),
    .clr   (kill),
    .count (pix_cnt),
    .wrap  (pix_wrap)
  );

  wrap_counter #(
    .W    (CH_W),
    .TERM (NUM_CHANNEL - 1)
  ) u_ch (
    .clk1  (clk1),
    .rst_n (rst_n),
    .en    (pix_wrap),
    .clr   (kill),
    .count (ch_idx),
    .wrap  (ch_wrap)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      end_channel <= 1'b0;
      end_layer   <= 1'b0;
    end else begin
      end_channel <= pix_wrap && !kill;
      end_layer   <= ch_wrap && !kill;
      if (kill) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:    if (start) state <= RUN;
          RUN:     if (pix_wrap) state <= ch_wrap ? IDLE : GAP;
          GAP:     state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_channel_sequencer.sv
// Bench for channel_sequencer: scoreboarded default instance
// plus a single-channel 4x4 instance.
module tb_channel_sequencer;

  localparam int CH_LEN = 84;
  localparam int NCH    = 3;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_n;
  logic        start;
  logic        ifm_valid;
  logic        abort_drv;
  logic        ifm_ready;
  logic [15:0] pix_cnt;
  logic [1:0]  ch_idx;
  logic        end_channel;
  logic        end_layer;
  logic        busy;

  logic        s_start;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_pix;
  logic [0:0]  s_ch;
  logic        s_endc;
  logic        s_endl;
  logic        s_busy;

  int checks = 0;
  int errors = 0;
  int acc_beats = 0;

  typedef struct packed {
    logic       last;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];
  int   m_state;
  int   m_pix;
  int   m_ch;
  logic m_endc;
  logic m_endl;

  channel_sequencer dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .start       (start),
    .ifm_valid   (ifm_valid),
`ifdef CHANNEL_SEQ_ABORT_EN
    .abort       (abort_drv),
`endif
    .ifm_ready   (ifm_ready),
    .pix_cnt     (pix_cnt),
    .ch_idx      (ch_idx),
    .end_channel (end_channel),
    .end_layer   (end_layer),
    .busy        (busy)
  );

  channel_sequencer #(
    .NUM_CHANNEL (1),
    .IFM_WIDTH   (4),
    .IFM_HEIGHT  (4),
    .KERNEL_SIZE (1)
  ) dut_s (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .start       (s_start),
    .ifm_valid   (s_valid),
`ifdef CHANNEL_SEQ_ABORT_EN
    .abort       (1'b0),
`endif
    .ifm_ready   (s_ready),
    .pix_cnt     (s_pix),
    .ch_idx      (s_ch),
    .end_channel (s_endc),
    .end_layer   (s_endl),
    .busy        (s_busy)
  );

  always @(posedge clk1) begin
    if (rst_n && ifm_valid && ifm_ready) acc_beats <= acc_beats + 1;
  end

  // Behavioural reference; pushes the expected pulse on each final beat.
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_pix   <= 0;
      m_ch    <= 0;
      m_endc  <= 1'b0;
      m_endl  <= 1'b0;
      sb.delete();
    end else begin
      m_endc <= 1'b0;
      m_endl <= 1'b0;
      if (abort_drv === 1'b1) begin
        m_state <= 0;
        m_pix   <= 0;
        m_ch    <= 0;
      end else if (m_state == 0) begin
        if (start) m_state <= 1;
      end else if (m_state == 2) begin
        m_state <= 1;
      end else if (ifm_valid) begin
        if (m_pix == CH_LEN - 1) begin
          m_pix  <= 0;
          m_endc <= 1'b1;
          if (m_ch == NCH - 1) begin
            m_ch    <= 0;
            m_endl  <= 1'b1;
            m_state <= 0;
            sb.push_back('{last: 1'b1, ch: 2'd0});
          end else begin
            m_ch    <= m_ch + 1;
            m_state <= 2;
            sb.push_back('{last: 1'b0, ch: 2'(m_ch + 1)});
          end
        end else begin
          m_pix <= m_pix + 1;
        end
      end
    end
  end

  always @(negedge clk1) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      checks = checks + 1;
      if (pix_cnt !== 16'(m_pix)) begin
        errors = errors + 1;
        $display("FAIL pix_cnt got %0d want %0d", pix_cnt, m_pix);
      end
      checks = checks + 1;
      if (ch_idx !== 2'(m_ch)) begin
        errors = errors + 1;
        $display("FAIL ch_idx got %0d want %0d", ch_idx, m_ch);
      end
      checks = checks + 1;
      if ({ifm_ready, busy} !== {m_state == 1, m_state != 0}) begin
        errors = errors + 1;
        $display("FAIL ready_busy got %b%b want state %0d", ifm_ready, busy, m_state);
      end
      checks = checks + 1;
      if ({end_channel, end_layer} !== {m_endc, m_endl}) begin
        errors = errors + 1;
        $display("FAIL pulses got %b%b want %b%b", end_channel, end_layer, m_endc, m_endl);
      end
      if (end_channel === 1'b1) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_empty end_channel with no expected entry");
        end else begin
          e = sb.pop_front();
          if ({end_layer, ch_idx} !== {e.last, e.ch}) begin
            errors = errors + 1;
            $display("FAIL sb_entry got %b/%0d want %b/%0d", end_layer, ch_idx, e.last, e.ch);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    ifm_valid = 1'b0;
    abort_drv = 1'b0;
    s_start   = 1'b0;
    s_valid   = 1'b0;
    repeat (2) @(negedge clk1);
    checks = checks + 1;
    if ({ifm_ready, pix_cnt, ch_idx, end_channel, end_layer, busy} !== 22'd0) begin
      errors = errors + 1;
      $display("FAIL reset_main got %b want 0",
               {ifm_ready, pix_cnt, ch_idx, end_channel, end_layer, busy});
    end
    checks = checks + 1;
    if ({s_ready, s_pix, s_ch, s_endc, s_endl, s_busy} !== 21'd0) begin
      errors = errors + 1;
      $display("FAIL reset_small got %b want 0",
               {s_ready, s_pix, s_ch, s_endc, s_endl, s_busy});
    end
    rst_n = 1'b1;
    @(negedge clk1);
  endtask

  task automatic test_full_layer();
    int b0;
    int n;
    int el;
    int ec[$];
    b0 = acc_beats;
    start = 1'b1;
    ifm_valid = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    n = 1;
    el = 0;
    while (el == 0 && n < 400) begin
      if (end_channel) ec.push_back(n);
      if (end_layer) el = n;
      else begin
        @(negedge clk1);
        n++;
      end
    end
    checks = checks + 1;
    if (el != 255) begin
      errors = errors + 1;
      $display("FAIL full_end_layer cycle %0d want 255", el);
    end
    checks = checks + 1;
    if (ec.size() != 3) begin
      errors = errors + 1;
      $display("FAIL full_ec_count got %0d want 3", ec.size());
    end else if (ec[0] != 85 || ec[1] != 170 || ec[2] != 255) begin
      errors = errors + 1;
      $display("FAIL full_ec_cycles got %0d %0d %0d want 85 170 255", ec[0], ec[1], ec[2]);
    end
    @(negedge clk1);
    checks = checks + 1;
    if (acc_beats - b0 != 252 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL full_beats got %0d busy %b want 252 busy 0", acc_beats - b0, busy);
    end
  endtask

  task automatic test_stall();
    int b0;
    int n;
    int el;
    int stalls;
    int nec;
    b0 = acc_beats;
    stalls = 0;
    nec = 0;
    start = 1'b1;
    ifm_valid = 1'b0;
    @(negedge clk1);
    start = 1'b0;
    n = 1;
    el = 0;
    while (el == 0 && n < 2000) begin
      if (end_channel) nec++;
      if (end_layer) el = n;
      else begin
        ifm_valid = 1'($urandom_range(0, 1));
        if (ifm_ready && !ifm_valid) stalls++;
        @(negedge clk1);
        n++;
      end
    end
    ifm_valid = 1'b1;
    checks = checks + 1;
    if (el != 255 + stalls) begin
      errors = errors + 1;
      $display("FAIL stall_end_layer cycle %0d want %0d", el, 255 + stalls);
    end
    checks = checks + 1;
    if (nec != 3) begin
      errors = errors + 1;
      $display("FAIL stall_ec_count got %0d want 3", nec);
    end
    @(negedge clk1);
    checks = checks + 1;
    if (acc_beats - b0 != 252) begin
      errors = errors + 1;
      $display("FAIL stall_beats got %0d want 252", acc_beats - b0);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    start = 1'b1;
    ifm_valid = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    n = 0;
    while (!(ch_idx == 2'd1 && pix_cnt == 16'd40) && n < 500) begin
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n >= 500) begin
      errors = errors + 1;
      $display("FAIL ign_reach timeout got %0d cycles want <500", n);
    end
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    checks = checks + 1;
    if ({ch_idx, pix_cnt, busy, ifm_ready} !== {2'd1, 16'd41, 2'b11}) begin
      errors = errors + 1;
      $display("FAIL ign_cont got ch %0d pix %0d bsy %b rdy %b want 1 41 1 1",
               ch_idx, pix_cnt, busy, ifm_ready);
    end
    n = 0;
    while (!end_layer && n < 500) begin
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n >= 500) begin
      errors = errors + 1;
      $display("FAIL ign_finish timeout got %0d want <500", n);
    end
    @(negedge clk1);
  endtask

  task automatic test_reset_mid();
    int n;
    int b0;
    logic bad;
    start = 1'b1;
    ifm_valid = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    n = 0;
    while (!(ch_idx == 2'd2 && pix_cnt == 16'd50) && n < 500) begin
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n >= 500) begin
      errors = errors + 1;
      $display("FAIL rmid_reach timeout got %0d want <500", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({ifm_ready, pix_cnt, ch_idx, end_channel, end_layer, busy} !== 22'd0) begin
      errors = errors + 1;
      $display("FAIL rmid_async got %b want 0",
               {ifm_ready, pix_cnt, ch_idx, end_channel, end_layer, busy});
    end
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      if (end_channel || end_layer || busy) bad = 1'b1;
    end
    checks = checks + 1;
    if (bad !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rmid_quiet got activity %b want 0", bad);
    end
    b0 = acc_beats;
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    n = 1;
    while (!end_layer && n < 400) begin
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n != 255) begin
      errors = errors + 1;
      $display("FAIL rmid_relayer cycle %0d want 255", n);
    end
    @(negedge clk1);
    checks = checks + 1;
    if (acc_beats - b0 != 252) begin
      errors = errors + 1;
      $display("FAIL rmid_beats got %0d want 252", acc_beats - b0);
    end
  endtask

  task automatic test_single_channel();
    int n;
    int beats;
    s_start = 1'b1;
    s_valid = 1'b1;
    @(negedge clk1);
    s_start = 1'b0;
    n = 1;
    beats = 0;
    while (!s_endc && n < 100) begin
      if (s_ready && s_valid) beats++;
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n != 18 || beats != 17) begin
      errors = errors + 1;
      $display("FAIL one_len cycle %0d beats %0d want 18 17", n, beats);
    end
    checks = checks + 1;
    if ({s_endl, s_ch, s_pix, s_busy} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL one_end got endl %b ch %0d pix %0d bsy %b want 1 0 0 0",
               s_endl, s_ch, s_pix, s_busy);
    end
    s_start = 1'b1;
    @(negedge clk1);
    s_start = 1'b0;
    checks = checks + 1;
    if ({s_busy, s_ready, s_endc} !== 3'b110) begin
      errors = errors + 1;
      $display("FAIL one_restart got %b want 110", {s_busy, s_ready, s_endc});
    end
    n = 1;
    while (!s_endc && n < 100) begin
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n != 18 || s_endl !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL one_second cycle %0d endl %b want 18 1", n, s_endl);
    end
    s_valid = 1'b0;
    @(negedge clk1);
  endtask

`ifdef CHANNEL_SEQ_ABORT_EN
  task automatic test_abort();
    int n;
    start = 1'b1;
    ifm_valid = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    n = 0;
    while (!(ch_idx == 2'd2 && pix_cnt == 16'(CH_LEN - 1)) && n < 500) begin
      @(negedge clk1);
      n++;
    end
    checks = checks + 1;
    if (n >= 500) begin
      errors = errors + 1;
      $display("FAIL abort_reach timeout got %0d want <500", n);
    end
    abort_drv = 1'b1;
    @(negedge clk1);
    checks = checks + 1;
    if ({busy, pix_cnt, ch_idx, end_channel, end_layer} !== 21'd0) begin
      errors = errors + 1;
      $display("FAIL abort_final got %b want 0",
               {busy, pix_cnt, ch_idx, end_channel, end_layer});
    end
    start = 1'b1;
    @(negedge clk1);
    abort_drv = 1'b0;
    start = 1'b0;
    checks = checks + 1;
    if ({busy, end_channel, end_layer} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL abort_start got %b want 000", {busy, end_channel, end_layer});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_layer();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_single_channel();
`ifdef CHANNEL_SEQ_ABORT_EN
    test_abort();
`endif
    repeat (2) @(negedge clk1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
